imm_gen_stage: RTL and testbench

- Registered, self-decoding immediate-generation stage between fetch/decode and execute.
- Classifies the immediate type from the opcode itself; no external type control.
- Builds the XLEN-wide immediate, adds CSR-uimm and shift-amount forms, flags illegal encodings, and precomputes pc+imm for PC-relative ops.
- Results pass through a 2-entry valid/ready skid buffer, so both handshakes are fully registered.

---
 rtl/imm_gen_stage_pkg.sv | 35 +++
 rtl/imm_gen_stage_core.sv | 92 +++++++++
 rtl/imm_gen_stage.sv | 133 +++++++++++++
 tb/tb_imm_gen_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared constants for the immediate-generation stage: XLEN width codes,
// immediate type codes, RV opcodes and a PC-relative opcode helper.
package imm_gen_stage_pkg;

    localparam logic [1:0] XLEN_32b = 2'd1;
    localparam logic [1:0] XLEN_64b = 2'd2;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_SH   = 3'd6,
        IMM_NONE = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // Opcodes whose result needs pc+imm precomputed.
    function automatic logic is_pc_rel(input logic [6:0] opc);
        return (opc == OPC_AUIPC) || (opc == OPC_JAL) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/imm_gen_stage_core.sv
// Combinational immediate decoder: classifies the opcode and builds the
// W-bit immediate, shift-arith flag and illegal-encoding flag.
module imm_expand_core
    import imm_gen_stage_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [31:0]  instr_i,
    output logic [W-1:0] imm_o,
    output imm_type_e    type_o,
    output logic         shift_arith_o,
    output logic         illegal_o
);

    logic [6:0] opcode_s;
    logic       is_shift_s;
    logic       wide_shamt_s;

    assign opcode_s   = instr_i[6:0];
    assign is_shift_s = (instr_i[14:12] == 3'b001) || (instr_i[14:12] == 3'b101);

    // Classify the immediate type and detect unsupported encodings.
    always_comb begin
        type_o       = IMM_NONE;
        illegal_o    = 1'b0;
        wide_shamt_s = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC: type_o = IMM_U;
            OPC_JAL:            type_o = IMM_J;
            OPC_JALR, OPC_LOAD: type_o = IMM_I;
            OPC_STORE:          type_o = IMM_S;
            OPC_BRANCH:         type_o = IMM_B;
            OPC_OP_IMM: begin
                if (is_shift_s) begin
                    type_o       = IMM_SH;
                    wide_shamt_s = (W == 64);
                    // 5-bit shamt forms reserve bit 25
                    illegal_o    = (W != 64) && instr_i[25];
                end else begin
                    type_o = IMM_I;
                end
            end
            OPC_OP_IMM_32: begin
                if (is_shift_s) begin
                    type_o    = IMM_SH;
                    illegal_o = instr_i[25];
                end else begin
                    type_o = IMM_I;
                end
                // word ops only exist on a 64-bit datapath
                illegal_o = illegal_o | (W != 64);
            end
            OPC_SYSTEM: begin
                if (instr_i[14]) begin
                    type_o = IMM_Z;
                end else begin
                    type_o = IMM_NONE;
                end
            end
            default: begin
                type_o    = IMM_NONE;
                illegal_o = 1'b1;
            end
        endcase
    end

    // Assemble the extended immediate for the decoded type.
    always_comb begin
        imm_o         = {W{1'b0}};
        shift_arith_o = 1'b0;
        case (type_o)
            IMM_I:  imm_o = W'($signed(instr_i[31:20]));
            IMM_S:  imm_o = W'($signed({instr_i[31:25], instr_i[11:7]}));
            IMM_B:  imm_o = W'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                        instr_i[11:8], 1'b0}));
            IMM_J:  imm_o = W'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                        instr_i[30:21], 1'b0}));
            IMM_U:  imm_o = W'($signed({instr_i[31:12], 12'h000}));
            IMM_Z:  imm_o = W'(instr_i[19:15]);
            IMM_SH: begin
                shift_arith_o = instr_i[30];
                if (wide_shamt_s) begin
                    imm_o = W'(instr_i[25:20]);
                end else begin
                    imm_o = W'(instr_i[24:20]);
                end
            end
            default: imm_o = {W{1'b0}};
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: decodes on the input side,
// precomputes pc+imm and stores results in a 2-entry skid buffer.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter logic [1:0] XLEN = XLEN_64b,
    localparam int        W    = 1 << (32'(XLEN) + 4)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [31:0]  i_instr,
    input  logic [W-1:0] i_pc,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_imm,
    output logic [2:0]   o_imm_type,
    output logic [W-1:0] o_target,
    output logic         o_shift_arith,
    output logic         o_illegal
);

    typedef struct packed {
        logic [W-1:0] imm;
        logic [W-1:0] target;
        logic [2:0]   imm_type;
        logic         shift_arith;
        logic         illegal;
    } entry_t;

    logic [W-1:0] imm_s;
    imm_type_e    type_s;
    logic         shift_arith_s;
    logic         illegal_s;
    entry_t       new_s;
    logic         push_s;
    logic         pop_s;

    // out_q is the head shown on the outputs; skid_q holds the second entry.
    logic [1:0]   count_q, count_d;
    entry_t       out_q, out_d;
    entry_t       skid_q, skid_d;

    imm_expand_core #(.W(W)) u_core (
        .instr_i       (i_instr),
        .imm_o         (imm_s),
        .type_o        (type_s),
        .shift_arith_o (shift_arith_s),
        .illegal_o     (illegal_s)
    );

    assign o_ready = (count_q != 2'd2);
    assign o_valid = (count_q != 2'd0);
    assign push_s  = i_valid && o_ready;
    assign pop_s   = o_valid && i_ready;

    // Package the decoded instruction with its precomputed branch target.
    always_comb begin
        new_s.imm         = imm_s;
        new_s.imm_type    = type_s;
        new_s.shift_arith = shift_arith_s;
        new_s.illegal     = illegal_s;
        if (is_pc_rel(i_instr[6:0])) begin
            new_s.target = i_pc + imm_s;
        end else begin
            new_s.target = {W{1'b0}};
        end
    end

    // Next state of the skid buffer for push/pop/flush.
    always_comb begin
        count_d = count_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (i_flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_s) begin
                        out_d   = new_s;
                        count_d = 2'd1;
                    end else begin
                        count_d = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        out_d = new_s;
                    end else if (push_s) begin
                        skid_d  = new_s;
                        count_d = 2'd2;
                    end else if (pop_s) begin
                        count_d = 2'd0;
                    end else begin
                        count_d = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        out_d   = skid_q;
                        count_d = 2'd1;
                    end else begin
                        count_d = 2'd2;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    // Buffer state registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= 2'd0;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign o_imm         = out_q.imm;
    assign o_imm_type    = out_q.imm_type;
    assign o_target      = out_q.target;
    assign o_shift_arith = out_q.shift_arith;
    assign o_illegal     = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomized self-checking bench for imm_gen_stage: a 64-bit and a 32-bit
// instance share stimulus and are compared against a queue-based model.
module tb_imm_gen_stage;
    import imm_gen_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, valid, ready;
    logic [31:0] instr;
    logic [63:0] pc;

    logic        rdy64, vld64, sa64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  typ64;
    logic        rdy32, vld32, sa32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  typ32;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(XLEN_64b)) u_dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid),
        .o_ready(rdy64), .i_instr(instr), .i_pc(pc), .o_valid(vld64),
        .i_ready(ready), .o_imm(imm64), .o_imm_type(typ64), .o_target(tgt64),
        .o_shift_arith(sa64), .o_illegal(ill64)
    );

    imm_gen_stage #(.XLEN(XLEN_32b)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(valid),
        .o_ready(rdy32), .i_instr(instr), .i_pc(pc[31:0]), .o_valid(vld32),
        .i_ready(ready), .o_imm(imm32), .o_imm_type(typ32), .o_target(tgt32),
        .o_shift_arith(sa32), .o_illegal(ill32)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  typ;
        logic        sa;
        logic        ill;
    } exp_t;

    typedef struct packed {
        exp_t e64;
        exp_t e32;
    } pair_t;

    pair_t q[$];
    pair_t last;
    bit    have_last;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the instruction-set rules with plain arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] p, input int w);
        exp_t        e;
        longint      v;
        logic [63:0] mask;
        logic [63:0] sum;
        logic [6:0]  opc;
        logic [2:0]  f3;
        bit          shift, pcrel;
        e     = '0;
        v     = 0;
        pcrel = 0;
        opc   = ins[6:0];
        f3    = ins[14:12];
        shift = (f3 == 3'b001) || (f3 == 3'b101);
        mask  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        e.typ = IMM_NONE;
        if (opc == OPC_LUI || opc == OPC_AUIPC) begin
            e.typ = IMM_U;
            v     = longint'($signed(ins[31:12])) * 4096;
            pcrel = (opc == OPC_AUIPC);
        end else if (opc == OPC_JAL) begin
            e.typ = IMM_J;
            v = -longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            pcrel = 1;
        end else if (opc == OPC_JALR || opc == OPC_LOAD) begin
            e.typ = IMM_I;
            v = -longint'(ins[31]) * 2048 + longint'(ins[30:20]);
        end else if (opc == OPC_STORE) begin
            e.typ = IMM_S;
            v = -longint'(ins[31]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
        end else if (opc == OPC_BRANCH) begin
            e.typ = IMM_B;
            v = -longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            pcrel = 1;
        end else if (opc == OPC_OP_IMM || opc == OPC_OP_IMM_32) begin
            if (shift) begin
                e.typ = IMM_SH;
                e.sa  = ins[30];
                if (w == 64 && opc == OPC_OP_IMM) begin
                    v = longint'(ins[25:20]);
                end else begin
                    v     = longint'(ins[25:20]) % 32;
                    e.ill = ins[25];
                end
            end else begin
                e.typ = IMM_I;
                v = -longint'(ins[31]) * 2048 + longint'(ins[30:20]);
            end
            if (opc == OPC_OP_IMM_32 && w != 64) e.ill = 1'b1;
        end else if (opc == OPC_SYSTEM) begin
            if (f3[2]) begin
                e.typ = IMM_Z;
                v     = longint'(ins[19:15]);
            end
        end else begin
            e.ill = 1'b1;
        end
        e.imm = 64'(v) & mask;
        sum   = p + 64'(v);
        e.tgt = pcrel ? (sum & mask) : 64'h0;
        return e;
    endfunction

    task automatic cmp_payload(input string tag, input pair_t x);
        check({tag, "_imm64"}, imm64, x.e64.imm);
        check({tag, "_typ64"}, {61'h0, typ64}, {61'h0, x.e64.typ});
        check({tag, "_tgt64"}, tgt64, x.e64.tgt);
        check({tag, "_sa64"},  {63'h0, sa64},  {63'h0, x.e64.sa});
        check({tag, "_ill64"}, {63'h0, ill64}, {63'h0, x.e64.ill});
        check({tag, "_imm32"}, {32'h0, imm32}, x.e32.imm);
        check({tag, "_typ32"}, {61'h0, typ32}, {61'h0, x.e32.typ});
        check({tag, "_tgt32"}, {32'h0, tgt32}, x.e32.tgt);
        check({tag, "_sa32"},  {63'h0, sa32},  {63'h0, x.e32.sa});
        check({tag, "_ill32"}, {63'h0, ill32}, {63'h0, x.e32.ill});
    endtask

    task automatic check_outs();
        check("valid64", {63'h0, vld64}, {63'h0, q.size() > 0});
        check("ready64", {63'h0, rdy64}, {63'h0, q.size() < 2});
        check("valid32", {63'h0, vld32}, {63'h0, q.size() > 0});
        check("ready32", {63'h0, rdy32}, {63'h0, q.size() < 2});
        if (q.size() > 0) begin
            cmp_payload("head", q[0]);
        end else if (have_last) begin
            cmp_payload("hold", last);
        end
    endtask

    // One clock of stimulus: check state left by the previous edge, drive, update model.
    task automatic cycle(input logic v, input logic r, input logic f,
                         input logic [31:0] ins, input logic [63:0] p);
        int    sz;
        pair_t x;
        @(negedge clk);
        check_outs();
        valid = v; ready = r; flush = f; instr = ins; pc = p;
        sz = q.size();
        if (f) begin
            q.delete();
            have_last = 0;
        end else begin
            if (sz > 0 && r) begin
                last      = q.pop_front();
                have_last = 1;
            end
            if (v && sz < 2) begin
                x.e64 = ref_decode(ins, p, 64);
                x.e32 = ref_decode(ins, {32'h0, p[31:0]}, 32);
                q.push_back(x);
            end
        end
    endtask

    // Push one instruction, stall one cycle, then check literal expectations.
    task automatic push_and_hold(input logic [31:0] ins, input logic [63:0] p);
        cycle(1'b1, 1'b1, 1'b0, ins, p);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [10];
        logic [31:0] ins;
        int          idx;
        opcs = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
                 OPC_STORE, OPC_OP_IMM, OPC_OP_IMM_32, OPC_SYSTEM};
        ins = $urandom;
        idx = $urandom_range(0, 11);
        if (idx < 10) ins[6:0] = opcs[idx];
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0;
        instr = 32'h0; pc = 64'h0;
        last = '0; have_last = 1;
        #12;
        check("rst_valid", {63'h0, vld64}, 64'h0);
        check("rst_ready", {63'h0, rdy64}, 64'h1);
        check("rst_imm",   imm64, 64'h0);
        check("rst_tgt",   tgt64, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1, x0, -1
        push_and_hold(32'hFFF00093, 64'h1000);
        check("addi_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_typ", {61'h0, typ64}, {61'h0, IMM_I});
        check("addi_tgt", tgt64, 64'h0);
        check("addi_ill", {63'h0, ill64}, 64'h0);

        push_and_hold(32'h0080006F, 64'h2000);
        check("jal_imm", imm64, 64'h8);
        check("jal_tgt", tgt64, 64'h2008);

        push_and_hold(32'hFE000EE3, 64'h0);
        check("beq_imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_tgt", tgt64, 64'hFFFF_FFFF_FFFF_FFFC);

        push_and_hold(32'h43F0D093, 64'h0);
        check("srai_typ", {61'h0, typ64}, {61'h0, IMM_SH});
        check("srai_imm", imm64, 64'd63);
        check("srai_sa",  {63'h0, sa64}, 64'h1);
        check("srai_ill", {63'h0, ill64}, 64'h0);
        check("srai_ill32", {63'h0, ill32}, 64'h1);

        push_and_hold(32'h000FD073, 64'h0);
        check("csri_imm", imm64, 64'h1F);
        check("csri_typ", {61'h0, typ64}, {61'h0, IMM_Z});
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);

        // backpressure: three pushes while stalled, third is held upstream
        cycle(1'b1, 1'b0, 1'b0, 32'h00100093, 64'h10);
        cycle(1'b1, 1'b0, 1'b0, 32'h00200093, 64'h20);
        cycle(1'b1, 1'b0, 1'b0, 32'h00300093, 64'h30);
        cycle(1'b1, 1'b0, 1'b0, 32'h00300093, 64'h30);
        check("full_ready", {63'h0, rdy64}, 64'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h00300093, 64'h30);
        cycle(1'b1, 1'b1, 1'b0, 32'h00300093, 64'h30);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);

        // flush while full with a simultaneous push
        cycle(1'b1, 1'b0, 1'b0, 32'h00400093, 64'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'h00500093, 64'h50);
        cycle(1'b1, 1'b1, 1'b1, 32'h7FF00093, 64'h60);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
        check("flush_valid", {63'h0, vld64}, 64'h0);
        check("flush_ready", {63'h0, rdy64}, 64'h1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);

        // asynchronous reset mid-stream with one entry held
        cycle(1'b1, 1'b0, 1'b0, 32'h00600093, 64'h70);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 64'h0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {63'h0, vld64}, 64'h0);
        check("arst_ready", {63'h0, rdy64}, 64'h1);
        check("arst_imm",   imm64, 64'h0);
        q.delete();
        last = '0; have_last = 1;
        @(negedge clk);
        rst_n = 1'b1;
        push_and_hold(32'h00700093, 64'h80);
        check("post_rst_valid", {63'h0, vld64}, 64'h1);
        check("post_rst_imm",   imm64, 64'h7);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 31) == 0, rand_instr(), {$urandom, $urandom});
        end
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
        cycle(1'b0, 1'b1, 1'b0, 32'h0, 64'h0);
        @(negedge clk);
        check_outs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
